// File: rtl/seq_pkg.sv
// seq_pkg: shared constants and types for the instruction sequencer.
//   - opcode constants and ALU opcode range
//   - PC-select (PS) encodings
//   - sequencer FSM state type
//   - instruction field positions (opcode, DA, SA, SB)
package seq_pkg;

    // Opcodes
    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_ALU_MIN = 4'h1;
    localparam logic [3:0] OP_ALU_MAX = 4'hB;
    localparam logic [3:0] OP_BRZ     = 4'hC;
    localparam logic [3:0] OP_BRN     = 4'hD;
    localparam logic [3:0] OP_JMP     = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    // PC select encodings
    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    // Instruction field positions
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned DA_MSB  = 11;
    localparam int unsigned DA_LSB  = 8;
    localparam int unsigned SA_MSB  = 7;
    localparam int unsigned SA_LSB  = 4;
    localparam int unsigned SB_MSB  = 3;
    localparam int unsigned SB_LSB  = 0;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALT    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/seq_decode.sv
// seq_decode: combinational opcode decoder for the EXECUTE cycle.
// Ports:
//   opcode  in  4  IR opcode field
//   Z, N    in  1  datapath zero / negative flags
//   ps      out 2  PC select to use in EXECUTE
//   rw      out 1  register-file write enable to use in EXECUTE
//   fs      out 4  ALU function select (opcode for ALU ops, else 0)
//   is_halt out 1  opcode is HALT
module seq_decode
    import seq_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       Z,
    input  logic       N,
    output logic [1:0] ps,
    output logic       rw,
    output logic [3:0] fs,
    output logic       is_halt
);

    logic is_alu;
    assign is_alu = (opcode >= OP_ALU_MIN) && (opcode <= OP_ALU_MAX);

    always_comb begin
        ps      = PS_INC;
        rw      = 1'b0;
        fs      = 4'h0;
        is_halt = 1'b0;
        if (is_alu) begin
            rw = 1'b1;
            fs = opcode;
        end else begin
            unique case (opcode)
                OP_NOP:  ps = PS_INC;
                OP_BRZ:  ps = Z ? PS_BR : PS_INC;
                OP_BRN:  ps = N ? PS_BR : PS_INC;
                OP_JMP:  ps = PS_JMP;
                OP_HALT: begin
                    ps      = PS_HOLD;
                    is_halt = 1'b1;
                end
                default: ps = PS_INC;
            endcase
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: FETCH/DECODE/EXECUTE/HALT control unit driving the PC select.
// Ports:
//   clk_main    in  1   clock (rising edge)
//   reset_n     in  1   asynchronous active-low reset
//   PC          in  6   current program counter
//   instr_addr  out 6   instruction memory address (= PC)
//   instr_req   out 1   fetch request, high in FETCH
//   instr       in  16  instruction word
//   instr_valid in  1   instr valid this cycle
//   Z, N        in  1   datapath flags, sampled in EXECUTE
//   go          in  1   resume from HALT
//   PS          out 2   PC select
//   SA, SB, DA  out 4   register addresses from IR ({SA,SB} is the branch offset)
//   FS          out 4   ALU function select
//   RW          out 1   register-file write enable
//   halted      out 1   high in HALT
module instruction_sequencer
    import seq_pkg::*;
(
    input  logic        clk_main,
    input  logic        reset_n,
    input  logic [5:0]  PC,
    output logic [5:0]  instr_addr,
    output logic        instr_req,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    input  logic        Z,
    input  logic        N,
    input  logic        go,
    output logic [1:0]  PS,
    output logic [3:0]  SA,
    output logic [3:0]  SB,
    output logic [3:0]  DA,
    output logic [3:0]  FS,
    output logic        RW,
    output logic        halted
);

    seq_state_t  state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [1:0]  dec_ps;
    logic        dec_rw;
    logic        dec_is_halt;

    assign instr_addr = PC;
    assign DA = ir_q[DA_MSB:DA_LSB];
    assign SA = ir_q[SA_MSB:SA_LSB];
    assign SB = ir_q[SB_MSB:SB_LSB];

    seq_decode u_decode (
        .opcode  (ir_q[OPC_MSB:OPC_LSB]),
        .Z       (Z),
        .N       (N),
        .ps      (dec_ps),
        .rw      (dec_rw),
        .fs      (FS),
        .is_halt (dec_is_halt)
    );

    always_ff @(posedge clk_main or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        PS        = PS_HOLD;
        RW        = 1'b0;
        instr_req = 1'b0;
        halted    = 1'b0;
        unique case (state_q)
            FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = EXECUTE;
            end
            EXECUTE: begin
                PS      = dec_ps;
                RW      = dec_rw;
                state_d = dec_is_halt ? HALT : FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (go) begin
                    PS      = PS_INC;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

endmodule
